// File: rtl/mpu_pkg.sv
// Definitions shared between the core, the result FIFO and their benches:
// datapath width, pointer-width helper, occupancy encoding.
package mpu_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      OCC_EMPTY,
      OCC_PARTIAL,
      OCC_FULL
   } occ_t;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/result_fifo_ram.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read, 0-cycle read latency.
// Reset zeroes every entry so an empty FIFO presents 0 on its read port.
module result_fifo_ram
   import mpu_pkg::*;
#(
   parameter int DATA_W = mpu_pkg::DATA_W,
   parameter int DEPTH  = 8,
   localparam int AW    = ptr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/result_fifo.sv
// ALU result buffer: push visible on out_data one edge later; no back-pressure to the core, overflow words
// are dropped and counted. RESULT_FIFO_DEDUP_EN suppresses pushes repeating the last pushed word.
module result_fifo
   import mpu_pkg::*;
#(
   parameter int DATA_W  = mpu_pkg::DATA_W,
   parameter int DEPTH   = 8,
   parameter int DROP_W  = 8,
   localparam int AW     = ptr_w(DEPTH),
   localparam int CNT_W  = ptr_w(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              overflow,
   output logic [DROP_W-1:0] drop_cnt,
   input  logic              clr_ovf
);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          accept;
   logic          pop;
   logic          push;
   logic          drop;

   assign full      = (count == CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;

`ifdef RESULT_FIFO_DEDUP_EN
   logic [DATA_W-1:0] last_data;
   logic              last_vld;

   // Repeats are filtered before the full check, so they can never become drops.
   assign accept = in_valid && !(last_vld && (in_data == last_data));

   always_ff @(posedge clk) begin
      if (rst) begin
         last_data <= '0;
         last_vld  <= 1'b0;
      end else if (push) begin
         last_data <= in_data;
         last_vld  <= 1'b1;
      end
   end
`else
   assign accept = in_valid;
`endif

   assign push = accept && (!full || pop);
   assign drop = accept && full && !pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   // A drop in the same cycle as clr_ovf wins and restarts the tally at 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (clr_ovf)             drop_cnt <= DROP_W'(1);
         else if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
      end else if (clr_ovf) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end
   end

   result_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data (in_data),
      .rd_addr (rd_ptr),
      .rd_data (out_data)
   );

endmodule

// File: tb/tb_result_fifo.sv
// Directed bench for result_fifo: reset, fill/drain, overflow and saturation, full push+pop, wrap, dedup.
module tb_result_fifo;
   import mpu_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] count;
   logic       full;
   logic       overflow;
   logic [7:0] drop_cnt;
   logic       clr_ovf = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   result_fifo dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count),
      .full      (full),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt),
      .clr_ovf   (clr_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic occ_t occ_of(input logic [3:0] c);
      if (c == 4'd0) return OCC_EMPTY;
      if (c == 4'd8) return OCC_FULL;
      return OCC_PARTIAL;
   endfunction

   initial begin
      logic [7:0] q[$];
      logic [7:0] dd_in [5];
      logic [7:0] dd_exp [5];
      int         dd_n;
      int         sent;
      int         cyc;
      logic       v;
      logic       r;
      logic       p_pop;
      logic       p_push;

      // Reset then idle
      repeat (2) step();
      rst = 1'b0;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'h00);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      chk("rst_occ", 32'(occ_of(count)), 32'(OCC_EMPTY));

      // Fill with out_ready low
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h11 * (i + 1));
         step();
         if (i == 0) begin
            chk("fallthru_valid", 32'(out_valid), 32'd1);
            chk("fallthru_data", 32'(out_data), 32'h11);
         end
      end
      in_valid = 1'b0;
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'd8);
      chk("fill_head", 32'(out_data), 32'h11);
      chk("fill_occ", 32'(occ_of(count)), 32'(OCC_FULL));

      // Overflow: 3 drops, then run on to saturate the counter
      in_valid = 1'b1;
      in_data  = 8'hAA;
      repeat (3) step();
      in_valid = 1'b0;
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_drop3", 32'(drop_cnt), 32'd3);
      chk("ovf_count", 32'(count), 32'd8);
      chk("ovf_head", 32'(out_data), 32'h11);
      in_valid = 1'b1;
      repeat (257) step();
      in_valid = 1'b0;
      chk("ovf_sat", 32'(drop_cnt), 32'd255);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      chk("clr_flag", 32'(overflow), 32'd0);
      chk("clr_drop", 32'(drop_cnt), 32'd0);

      // Drop in the same cycle as clear: drop wins
      clr_ovf  = 1'b1;
      in_valid = 1'b1;
      step();
      clr_ovf  = 1'b0;
      in_valid = 1'b0;
      chk("clrdrop_flag", 32'(overflow), 32'd1);
      chk("clrdrop_cnt", 32'(drop_cnt), 32'd1);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;

      // Full push+pop
      in_valid  = 1'b1;
      in_data   = 8'h99;
      out_ready = 1'b1;
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("pp_count", 32'(count), 32'd8);
      chk("pp_drop", 32'(drop_cnt), 32'd0);
      chk("pp_ovf", 32'(overflow), 32'd0);
      chk("pp_head", 32'(out_data), 32'h22);

      // Drain: 22..88 then 99
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("drain_valid", 32'(out_valid), 32'd1);
         chk("drain_data", 32'(out_data), (i < 7) ? 32'(8'h11 * (i + 2)) : 32'h99);
         step();
      end
      out_ready = 1'b0;
      chk("drain_empty", 32'(out_valid), 32'd0);
      chk("drain_count", 32'(count), 32'd0);

      // Wrap with random out_ready, scoreboarded
      sent = 0;
      cyc  = 0;
      while ((sent < 20 || q.size() > 0) && cyc < 500) begin
         v = (sent < 20) && ($urandom_range(0, 3) != 0);
         r = 1'($urandom_range(0, 1));
         in_valid  = v;
         in_data   = 8'(8'h30 + sent);
         out_ready = r;
         p_pop  = (q.size() > 0) && r;
         p_push = v && ((q.size() < 8) || p_pop);
         if (p_pop) chk("wrap_data", 32'(out_data), 32'(q[0]));
         step();
         if (p_pop) void'(q.pop_front());
         if (p_push) begin
            q.push_back(8'(8'h30 + sent));
            sent++;
         end
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("wrap_in_budget", 32'(cyc < 500), 32'd1);
      chk("wrap_count", 32'(count), 32'd0);

      // Reset mid-stream with 5 entries queued
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h41 + i);
         step();
      end
      in_valid = 1'b0;
      chk("mid_count5", 32'(count), 32'd5);
      chk("mid_occ", 32'(occ_of(count)), 32'(OCC_PARTIAL));
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_data", 32'(out_data), 32'h00);

      // Repeated words
      dd_in[0] = 8'h05; dd_in[1] = 8'h05; dd_in[2] = 8'h05; dd_in[3] = 8'h07; dd_in[4] = 8'h05;
`ifdef RESULT_FIFO_DEDUP_EN
      dd_n = 3;
      dd_exp[0] = 8'h05; dd_exp[1] = 8'h07; dd_exp[2] = 8'h05; dd_exp[3] = 8'h00; dd_exp[4] = 8'h00;
`else
      dd_n = 5;
      dd_exp = dd_in;
`endif
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = dd_in[i];
         step();
      end
      in_valid = 1'b0;
      chk("dd_count", 32'(count), 32'(dd_n));
      chk("dd_drop", 32'(drop_cnt), 32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < dd_n; i++) begin
         chk("dd_data", 32'(out_data), 32'(dd_exp[i]));
         step();
      end
      out_ready = 1'b0;
      chk("dd_empty", 32'(out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
